neuron_lut_scheduler: RTL and testbench

NEURON_LUT_SCHEDULER -- requirements
Module: neuron_lut_scheduler

---
 rtl/neuron_lut_scheduler.sv | 176 +++++++++++++++++
 tb/tb_neuron_lut_scheduler.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/neuron_lut_scheduler.sv
// neuron_lut_scheduler
// Time-shares a single 7-input/2-output LUT datapath across NUM_NEURONS neurons.
// A frame of pre-gathered LUT addresses is latched, one lookup is issued per
// cycle, the returned 2-bit results are assembled into out_data, and the frame
// is held until downstream accepts it.
module neuron_lut_scheduler #(
    parameter int NUM_NEURONS = 8,
    parameter int SEL_W       = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7*NUM_NEURONS-1:0]   in_data,
    output logic                       lut_req,
    output logic [SEL_W-1:0]           lut_sel,
    output logic [6:0]                 lut_addr,
    input  logic [1:0]                 lut_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*NUM_NEURONS-1:0]   out_data,
    output logic [15:0]                frame_count
);

    localparam int K_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // FSM state and datapath registers
    state_e                              state_q, state_d;
    logic [K_W-1:0]                      k_q, k_d;
    logic [NUM_NEURONS-1:0][6:0]         frame_q, frame_d;
    logic [NUM_NEURONS-1:0][1:0]         res_q, res_d;
    logic                                rd_pend_q, rd_pend_d;
    logic [K_W-1:0]                      rd_sel_q, rd_sel_d;
    logic [15:0]                         frame_count_q, frame_count_d;

    // Frame is taken only while the block advertises readiness
    logic accept_s;
    logic deliver_s;

    assign accept_s  = in_valid && in_ready;
    assign deliver_s = (state_q == ST_DONE) && out_ready;

    assign out_data    = res_q;
    assign frame_count = frame_count_q;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            frame_q       <= '0;
            res_q         <= '0;
            rd_pend_q     <= 1'b0;
            rd_sel_q      <= '0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            frame_q       <= frame_d;
            res_q         <= res_d;
            rd_pend_q     <= rd_pend_d;
            rd_sel_q      <= rd_sel_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Next-state logic: accept, issue every neuron, drain last result, hold
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state; select/address are
    // forced to zero whenever no lookup is being issued
    always_comb begin
        in_ready  = 1'b0;
        lut_req   = 1'b0;
        lut_sel   = '0;
        lut_addr  = 7'd0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // held low while reset is asserted so nothing is offered
                in_ready = ~rst;
            end
            ST_ISSUE: begin
                lut_req  = 1'b1;
                lut_sel  = SEL_W'(k_q);
                lut_addr = frame_q[k_q];
            end
            ST_DRAIN: begin
                lut_req = 1'b0;
            end
            ST_DONE: begin
                out_valid = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath: neuron index, frame latch, result assembly, delivery counter
    always_comb begin
        k_d           = k_q;
        frame_d       = frame_q;
        res_d         = res_q;
        frame_count_d = frame_count_q;
        // remember which neuron was looked up so its result lands next cycle
        rd_pend_d     = lut_req;
        rd_sel_d      = k_q;

        if (accept_s) begin
            frame_d = in_data;
            k_d     = '0;
        end else if ((state_q == ST_ISSUE) && (k_q != K_LAST)) begin
            k_d = k_q + K_W'(1);
        end else if (state_q == ST_ISSUE) begin
            k_d = '0;
        end else begin
            k_d = k_q;
        end

        // a fresh frame starts from an all-zero result vector
        if (accept_s) begin
            res_d = '0;
        end else if (rd_pend_q) begin
            res_d[rd_sel_q] = lut_rdata;
        end else begin
            res_d = res_q;
        end

        if (deliver_s) begin
            frame_count_d = frame_count_q + 16'd1;
        end else begin
            frame_count_d = frame_count_q;
        end
    end

endmodule

// File: tb/tb_neuron_lut_scheduler.sv
// Directed testbench for neuron_lut_scheduler with NUM_NEURONS=4 and a
// one-cycle LUT model returning lut_addr[1:0] ^ lut_sel[1:0].
module tb_neuron_lut_scheduler;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] in_data;
    logic        lut_req;
    logic [5:0]  lut_sel;
    logic [6:0]  lut_addr;
    logic [1:0]  lut_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] frame_count;

    int checks   = 0;
    int failures = 0;
    int exp_fc   = 0;

    neuron_lut_scheduler #(.NUM_NEURONS(4), .SEL_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .lut_req    (lut_req),
        .lut_sel    (lut_sel),
        .lut_addr   (lut_addr),
        .lut_rdata  (lut_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LUT model: one-cycle latency
    always @(posedge clk) lut_rdata <= lut_addr[1:0] ^ lut_sel[1:0];

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = 28'd0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (lut_req !== 1'b0) begin failures++; $display("FAIL reset_lut_req got=%b exp=0", lut_req); end
        checks++; if (lut_sel !== 6'd0 || lut_addr !== 7'd0) begin failures++; $display("FAIL reset_sel_addr got=%h/%h exp=0/0", lut_sel, lut_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (frame_count !== 16'd0) begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_frame;
        in_data = {7'h03, 7'h02, 7'h01, 7'h00}; in_valid = 1'b1; out_ready = 1'b1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_accept in_ready got=%b exp=1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 28'h5A5A5A5;
            checks++;
            if (lut_req !== 1'b1 || lut_sel !== 6'(k) || lut_addr !== 7'(k)) begin
                failures++;
                $display("FAIL single_issue k=%0d got req=%b sel=%0d addr=%h exp req=1 sel=%0d addr=%h", k, lut_req, lut_sel, lut_addr, k, k);
            end
        end
        @(negedge clk);
        checks++; if (lut_req !== 1'b0 || lut_sel !== 6'd0 || lut_addr !== 7'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL single_drain got req=%b sel=%h addr=%h ov=%b exp 0/0/0/0", lut_req, lut_sel, lut_addr, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h00 || in_ready !== 1'b0) begin
            failures++; $display("FAIL single_done got ov=%b data=%h ir=%b exp ov=1 data=00 ir=0", out_valid, out_data, in_ready); end
        @(negedge clk);
        exp_fc++;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_count !== 16'(exp_fc)) begin
            failures++; $display("FAIL single_after got ov=%b ir=%b fc=%0d exp ov=0 ir=1 fc=%0d", out_valid, in_ready, frame_count, exp_fc); end
    endtask

    task automatic test_back_pressure;
        in_data = {7'h01, 7'h01, 7'h01, 7'h01}; in_valid = 1'b1; out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; in_data = 28'hFFFFFFF;
        repeat (5) @(negedge clk);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hB1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got ov=%b data=%h ir=%b exp ov=1 data=b1 ir=0", i, out_valid, out_data, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        exp_fc++;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_count !== 16'(exp_fc)) begin
            failures++; $display("FAIL bp_release got ov=%b ir=%b fc=%0d exp ov=0 ir=1 fc=%0d", out_valid, in_ready, frame_count, exp_fc); end
    endtask

    task automatic test_back_to_back;
        logic [6:0] ea [4];
        ea = '{7'h45, 7'h22, 7'h10, 7'h7F};
        in_data = {7'h7F, 7'h10, 7'h22, 7'h45}; in_valid = 1'b1; out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            if (f > 0) @(negedge clk);
            checks++; if (in_ready !== 1'b1 || frame_count !== 16'(exp_fc)) begin
                failures++; $display("FAIL b2b_start f=%0d got ir=%b fc=%0d exp ir=1 fc=%0d", f, in_ready, frame_count, exp_fc); end
            for (int j = 1; j <= 6; j++) begin
                @(negedge clk);
                checks++;
                if (j <= 4) begin
                    if (in_ready !== 1'b0 || lut_req !== 1'b1 || lut_sel !== 6'(j - 1) || lut_addr !== ea[j - 1]) begin
                        failures++;
                        $display("FAIL b2b_issue f=%0d j=%0d got ir=%b req=%b sel=%0d addr=%h exp ir=0 req=1 sel=%0d addr=%h", f, j, in_ready, lut_req, lut_sel, lut_addr, j - 1, ea[j - 1]);
                    end
                end else begin
                    if (in_ready !== 1'b0 || lut_req !== 1'b0) begin
                        failures++; $display("FAIL b2b_gap f=%0d j=%0d got ir=%b req=%b exp ir=0 req=0", f, j, in_ready, lut_req); end
                end
            end
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h2D) begin
                failures++; $display("FAIL b2b_result f=%0d got ov=%b data=%h exp ov=1 data=2d", f, out_valid, out_data); end
            exp_fc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (frame_count !== 16'(exp_fc) || in_ready !== 1'b1) begin
            failures++; $display("FAIL b2b_count got fc=%0d ir=%b exp fc=%0d ir=1", frame_count, in_ready, exp_fc); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_issue;
        in_data = {7'h01, 7'h01, 7'h02, 7'h01}; in_valid = 1'b1; out_ready = 1'b1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_accept in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (lut_req !== 1'b0 || lut_sel !== 6'd0 || lut_addr !== 7'd0) begin
            failures++; $display("FAIL rmid_req got req=%b sel=%h addr=%h exp 0/0/0", lut_req, lut_sel, lut_addr); end
        exp_fc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || frame_count !== 16'd0 || out_data !== 8'h00) begin
                failures++; $display("FAIL rmid_idle cyc=%0d got ov=%b fc=%0d data=%h exp ov=0 fc=0 data=00", i, out_valid, frame_count, out_data);
            end
        end
        in_data = {7'h7F, 7'h10, 7'h22, 7'h45}; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h2D) begin
            failures++; $display("FAIL rmid_next got ov=%b data=%h exp ov=1 data=2d", out_valid, out_data); end
        @(negedge clk);
        exp_fc++;
        checks++; if (frame_count !== 16'(exp_fc)) begin
            failures++; $display("FAIL rmid_count got=%0d exp=%0d", frame_count, exp_fc); end
    endtask

    task automatic test_counter_wrap;
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_count_q;
        @(negedge clk);
        checks++; if (frame_count !== 16'hFFFF) begin
            failures++; $display("FAIL wrap_preload got=%h exp=ffff", frame_count); end
        in_data = {7'h01, 7'h01, 7'h01, 7'h01}; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hB1 || frame_count !== 16'hFFFF) begin
            failures++; $display("FAIL wrap_done got ov=%b data=%h fc=%h exp ov=1 data=b1 fc=ffff", out_valid, out_data, frame_count); end
        @(negedge clk);
        checks++; if (frame_count !== 16'h0000) begin
            failures++; $display("FAIL wrap_count got=%h exp=0000", frame_count); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_issue();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
